adpll_lock_monitor: RTL and testbench
=====================================

Name: adpll_lock_monitor

Overview:
- Observer at the output end of the ring ADPLL.
- Consumes the loop's phase error, DCO control code and generated clock, all referenced to the reference clock.
- Decides lock status in the fpga_clk_i domain by counting gen_clk edges per reference period.
- Drives lock/loss indications, a window gen-edge count and a state code for on-board LEDs, debug and test-bench checking.

Parameters:
- DIV_RATIO, 1: expected gen_clk rising edges per ref_clk period.
- CNT_W, 8: width of the gen-edge window counter; saturates at 2^CNT_W-1.
- CNT_TOL, 0: allowed |gen_count - DIV_RATIO| for a good window.
- ERR_TOL, 4: allowed |error_i| for a good window.
- LOCK_COUNT, 16: consecutive good windows required to declare lock.
- UNLOCK_COUNT, 4: consecutive bad windows in LOCKED that declare loss of lock.

Ports:
- fpga_clk_i, in, 1: sole clock, about 258 MHz.
- reset_i, in, 1: asynchronous, active-high reset.
- enable_i, in, 1: monitor enable; low forces IDLE.
- ref_clk_i, in, 1: reference clock, asynchronous to fpga_clk_i.
- gen_clk_i, in, 1: ADPLL generated clock, asynchronous.
- error_i, in, 8: signed phase error from the ADPLL, fpga_clk_i domain.
- dco_cc_i, in, 5: signed DCO control code from the ADPLL.
- locked_o, out, 1: high while in LOCKED.
- lock_lost_o, out, 1: one-cycle pulse on the LOCKED->ACQUIRE transition.
- state_o, out, 2: 00 IDLE, 01 ACQUIRE, 10 LOCKED.
- gen_count_o, out, CNT_W: gen-edge count of the last closed window.
- window_good_o, out, 1: verdict of the last closed window.

Behaviour:
- Async reset: state IDLE, all counters 0, all outputs 0, synchronizers 0.
- Input sync: ref_clk_i and gen_clk_i each pass through a 2-flop synchronizer plus a registered edge detector.
  - ref_tick and gen_tick are single-cycle rising-edge strobes, 3 fpga_clk_i cycles after the input edge.
- Window counter: increments on gen_tick and saturates at all-ones.
  - On ref_tick, the current count (plus the concurrent gen_tick, if any) closes into gen_count_o, and the counter reloads to 0.
  - A gen_tick coincident with ref_tick belongs to the closing window, so the reload value is 0.
- Window verdict on ref_tick, registered with gen_count_o one cycle later. A window is good iff all of:
  - |error_i| <= ERR_TOL, with |error_i| computed in 9 bits so that -128 gives 128;
  - |gen_count - DIV_RATIO| <= CNT_TOL, computed in CNT_W+1 signed bits;
  - dco_cc_i is not railed (not -16 and not +15).
  - error_i and dco_cc_i are sampled in the ref_tick cycle.
- FSM transitions evaluate on ref_tick only (except the enable_i rules below):
  - IDLE: on enable_i=1 go to ACQUIRE with good_cnt=0 and the discard flag set.
  - ACQUIRE:
    - The first ref_tick after entry only resets the window and clears the discard flag; no verdict.
    - Good window: good_cnt++. When it reaches LOCK_COUNT, go to LOCKED and clear bad_cnt.
    - Bad window: good_cnt=0.
  - LOCKED:
    - Good window: bad_cnt=0.
    - Bad window: bad_cnt++. At UNLOCK_COUNT, go to ACQUIRE, pulse lock_lost_o, and set good_cnt=0.
    - Re-entry from LOCKED has no discard window.
- enable_i=0 in any state: IDLE on the next clock; counters and gen_count_o cleared; no lock_lost_o pulse.
  - This takes priority over a simultaneous ref_tick.
- locked_o and state_o are registered from the state register.
- lock_lost_o is high exactly one cycle.
- Missing gen_clk (stuck level) yields gen_count 0, i.e. a bad window.
- Missing ref_clk holds state indefinitely; this is intentional and no watchdog is provided.
- Reset mid-window discards the partial window.

Test Plan:
- Default parameters, gen_clk = ref_clk (100 ns half period), error_i=0, dco_cc_i=0.
  - Expect locked_o rising on the cycle after the 17th ref_tick (1 discard + 16 good), gen_count_o=1, window_good_o=1.
- From lock, force error_i=+5 for 4 ref periods.
  - Expect lock_lost_o single pulse after the 4th, then state_o=01.
  - Then error_i=0 and 16 more periods: relock.
- From lock, 3 bad windows, 1 good, 3 bad.
  - Expect locked_o to stay 1 and lock_lost_o never to pulse.
- DIV_RATIO=8, CNT_TOL=0, gen_clk half period 12.5 ns, ref 200 ns period: gen_count_o=8 and lock.
  - Then gen_clk half period 11 ns: count 9, bad windows, loss after 4.
- dco_cc_i=-16 with error_i=0 and correct frequency: window_good_o=0 and no lock. Separately, error_i=-128: bad window.
- Two cases while LOCKED:
  - Deassert enable_i exactly on a ref_tick cycle: next cycle state_o=00, locked_o=0, lock_lost_o=0.
  - Assert reset_i asynchronously mid-window: outputs 0 immediately.

Source files
------------

// File: rtl/adpll_lock_monitor.sv
// Lock observer for the ring ADPLL: counts gen_clk edges per ref_clk period in the
// fpga_clk_i domain and tracks IDLE / ACQUIRE / LOCKED from per-window verdicts.
module adpll_lock_monitor #(
    parameter int DIV_RATIO    = 1,
    parameter int CNT_W        = 8,
    parameter int CNT_TOL      = 0,
    parameter int ERR_TOL      = 4,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic             fpga_clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             ref_clk_i,
    input  logic             gen_clk_i,
    input  logic [7:0]       error_i,
    input  logic [4:0]       dco_cc_i,
    output logic             locked_o,
    output logic             lock_lost_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] gen_count_o,
    output logic             window_good_o
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam logic signed [CNT_W:0] DIV_S = (CNT_W + 1)'(DIV_RATIO);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ref_sh_q, ref_sh_d;
    logic [2:0]         gen_sh_q, gen_sh_d;
    logic               ref_tick_q, ref_tick_d;
    logic               gen_tick_q, gen_tick_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   gen_count_q, gen_count_d;
    logic               window_good_q, window_good_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic               discard_q, discard_d;
    logic               lock_lost_q, lock_lost_d;

    logic [CNT_W-1:0]   win_next;
    logic [8:0]         err_ext, err_abs;
    logic signed [CNT_W:0] cnt_diff;
    logic [CNT_W:0]     cnt_abs;
    logic               good, verdict, lock_hit, unlock_hit;

    // Synchronizer chain: [0] meta, [1] synced, [2] previous synced value.
    always_comb begin
        ref_sh_d   = {ref_sh_q[1:0], ref_clk_i};
        gen_sh_d   = {gen_sh_q[1:0], gen_clk_i};
        ref_tick_d = ref_sh_q[1] & ~ref_sh_q[2];
        gen_tick_d = gen_sh_q[1] & ~gen_sh_q[2];
    end

    always_comb begin
        win_next = win_cnt_q;
        if (gen_tick_q && (win_cnt_q != '1)) begin
            win_next = win_cnt_q + 1'b1;
        end
        err_ext = {error_i[7], error_i};
        err_abs = err_ext[8] ? (~err_ext + 9'd1) : err_ext;
        cnt_diff = $signed({1'b0, win_next}) - DIV_S;
        cnt_abs  = cnt_diff[CNT_W] ? (CNT_W + 1)'(-cnt_diff) : (CNT_W + 1)'(cnt_diff);
        good = (err_abs <= 9'(ERR_TOL))
            && (cnt_abs <= (CNT_W + 1)'(CNT_TOL))
            && (dco_cc_i != 5'b10000) && (dco_cc_i != 5'b01111);
        verdict    = enable_i && ref_tick_q && !discard_q;
        lock_hit   = verdict && (state_q == ACQUIRE) && good
                  && (good_cnt_q == GOOD_W'(LOCK_COUNT - 1));
        unlock_hit = verdict && (state_q == LOCKED) && !good
                  && (bad_cnt_q == BAD_W'(UNLOCK_COUNT - 1));
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ACQUIRE;
                ACQUIRE: if (lock_hit) state_d = LOCKED;
                LOCKED:  if (unlock_hit) state_d = ACQUIRE;
                default: state_d = IDLE;
            endcase
        end
        lock_lost_d = unlock_hit;
    end

    // Disable clears everything ahead of any coincident window close.
    always_comb begin
        win_cnt_d     = win_next;
        gen_count_d   = gen_count_q;
        window_good_d = window_good_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        discard_d     = discard_q;
        if (!enable_i) begin
            win_cnt_d     = '0;
            gen_count_d   = '0;
            window_good_d = 1'b0;
            good_cnt_d    = '0;
            bad_cnt_d     = '0;
            discard_d     = 1'b0;
        end else if (state_q == IDLE) begin
            win_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            discard_d  = 1'b1;
        end else if (ref_tick_q) begin
            win_cnt_d = '0;
            if (discard_q) begin
                discard_d = 1'b0;
            end else begin
                gen_count_d   = win_next;
                window_good_d = good;
                if (state_q == ACQUIRE) begin
                    if (!good || lock_hit) good_cnt_d = '0;
                    else good_cnt_d = good_cnt_q + 1'b1;
                    if (lock_hit) bad_cnt_d = '0;
                end else if (state_q == LOCKED) begin
                    if (good || unlock_hit) bad_cnt_d = '0;
                    else bad_cnt_d = bad_cnt_q + 1'b1;
                    if (unlock_hit) good_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            ref_sh_q      <= '0;
            gen_sh_q      <= '0;
            ref_tick_q    <= 1'b0;
            gen_tick_q    <= 1'b0;
            win_cnt_q     <= '0;
            gen_count_q   <= '0;
            window_good_q <= 1'b0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            discard_q     <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_sh_q      <= ref_sh_d;
            gen_sh_q      <= gen_sh_d;
            ref_tick_q    <= ref_tick_d;
            gen_tick_q    <= gen_tick_d;
            win_cnt_q     <= win_cnt_d;
            gen_count_q   <= gen_count_d;
            window_good_q <= window_good_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            discard_q     <= discard_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    always_comb begin
        locked_o      = (state_q == LOCKED);
        state_o       = state_q;
        lock_lost_o   = lock_lost_q;
        gen_count_o   = gen_count_q;
        window_good_o = window_good_q;
    end

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Scoreboard bench for adpll_lock_monitor: DIV_RATIO=1 and DIV_RATIO=8 instances,
// one expected record queued per ref_clk window, checked after the sync latency.
`timescale 1ns/100ps
module tb_adpll_lock_monitor;

    typedef struct {
        logic [7:0] gc;
        logic       wg;
        logic [1:0] st;
        logic       lost;
    } exp_t;

    logic       clk;
    logic [1:0] rst, en, refc, gen;
    logic [7:0] err [2];
    logic [4:0] dco [2];
    logic [1:0] locked, lost;
    logic [1:0] st [2];
    logic [7:0] gc [2];
    logic [1:0] wg;

    exp_t q0[$], q1[$];
    int checks = 0;
    int errors = 0;
    int lost_cnt [2] = '{0, 0};

    int m_state [2], m_good [2], m_bad [2], m_disc [2], m_prev [2], m_lost [2];
    logic [7:0] m_gc [2];
    logic       m_wg [2];

    logic [7:0] p4e [8] = '{8'd5, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0};
    logic [4:0] p4c [8] = '{5'd0, 5'd0, 5'h10, 5'd0, 5'h0F, 5'd0, 5'd0, 5'd0};
    int         p4g [8] = '{1, 1, 1, 1, 1, 0, 1, 1};

    adpll_lock_monitor u_dut1 (
        .fpga_clk_i(clk), .reset_i(rst[0]), .enable_i(en[0]), .ref_clk_i(refc[0]),
        .gen_clk_i(gen[0]), .error_i(err[0]), .dco_cc_i(dco[0]), .locked_o(locked[0]),
        .lock_lost_o(lost[0]), .state_o(st[0]), .gen_count_o(gc[0]), .window_good_o(wg[0])
    );

    adpll_lock_monitor #(.DIV_RATIO(8), .CNT_TOL(0)) u_dut8 (
        .fpga_clk_i(clk), .reset_i(rst[1]), .enable_i(en[1]), .ref_clk_i(refc[1]),
        .gen_clk_i(gen[1]), .error_i(err[1]), .dco_cc_i(dco[1]), .locked_o(locked[1]),
        .lock_lost_o(lost[1]), .state_o(st[1]), .gen_count_o(gc[1]), .window_good_o(wg[1])
    );

    // Posedges at 2.7 + 4k ns never coincide with stimulus edges on the 0.5 ns grid.
    initial begin
        clk = 1'b0;
        #0.7;
        forever #2 clk = ~clk;
    end

    always @(negedge clk) begin
        if (lost[0] === 1'b1) lost_cnt[0]++;
        if (lost[1] === 1'b1) lost_cnt[1]++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_start(input int d);
        m_state[d] = 1; m_disc[d] = 1; m_good[d] = 0; m_bad[d] = 0;
        m_prev[d] = 0; m_gc[d] = '0; m_wg[d] = 1'b0;
    endtask

    // One 200 ns ref window: ref rises at call start and closes the previous window.
    // coinc: gen edge with ref (counted in the closing window); npulse: gen pulses
    // later in this period (counted in the next window).
    task automatic win(input int d, input logic [7:0] e, input logic [4:0] c, input int coinc,
                       input int npulse, input real h, input real off, input bit drop);
        int   cnt, ea, cd;
        logic good;
        exp_t x;
        err[d] = e;
        dco[d] = c;
        cnt = m_prev[d] + coinc;
        m_prev[d] = npulse;
        ea = $signed(e);
        if (ea < 0) ea = -ea;
        cd = cnt - ((d == 0) ? 1 : 8);
        if (cd < 0) cd = -cd;
        good = (ea <= 4) && (cd == 0) && (c != 5'h10) && (c != 5'h0F);
        x.lost = 1'b0;
        if (drop) begin
            m_state[d] = 0; m_good[d] = 0; m_bad[d] = 0; m_disc[d] = 0;
            m_gc[d] = '0; m_wg[d] = 1'b0;
        end else if (m_disc[d] != 0) begin
            m_disc[d] = 0;
        end else begin
            m_gc[d] = 8'(cnt);
            m_wg[d] = good;
            if (m_state[d] == 1) begin
                if (good) begin
                    m_good[d]++;
                    if (m_good[d] == 16) begin m_state[d] = 2; m_bad[d] = 0; end
                end else m_good[d] = 0;
            end else if (m_state[d] == 2) begin
                if (good) m_bad[d] = 0;
                else begin
                    m_bad[d]++;
                    if (m_bad[d] == 4) begin
                        m_state[d] = 1; m_good[d] = 0; m_bad[d] = 0;
                        x.lost = 1'b1; m_lost[d]++;
                    end
                end
            end
        end
        x.gc = m_gc[d]; x.wg = m_wg[d]; x.st = 2'(m_state[d]);
        if (d == 0) q0.push_back(x); else q1.push_back(x);
        fork
            begin
                refc[d] = 1'b1;
                if (coinc != 0) gen[d] = 1'b1;
                #100;
                refc[d] = 1'b0;
                if (coinc != 0) gen[d] = 1'b0;
                #100;
            end
            begin
                if (npulse > 0) begin
                    #(off);
                    for (int j = 0; j < npulse; j++) begin
                        gen[d] = 1'b1;
                        #(h);
                        gen[d] = 1'b0;
                        if (j < npulse - 1) #(h);
                    end
                end
            end
            begin
                if (drop) begin
                    repeat (3) @(posedge clk);
                    #1 en[d] = 1'b0;
                end
            end
        join
    endtask

    // Window results appear four fpga_clk edges after the ref rising edge.
    task automatic monitor(input int d);
        exp_t e;
        forever begin
            if (d == 0) @(posedge refc[0]); else @(posedge refc[1]);
            repeat (4) @(posedge clk);
            @(negedge clk);
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL dut%0d scoreboard: window closed with no expectation queued", d);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                check($sformatf("dut%0d gen_count_o", d), gc[d], e.gc);
                check($sformatf("dut%0d window_good_o", d), wg[d], e.wg);
                check($sformatf("dut%0d state_o", d), st[d], e.st);
                check($sformatf("dut%0d locked_o", d), locked[d], (e.st == 2'b10));
                check($sformatf("dut%0d lock_lost_o", d), lost[d], e.lost);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        rst = 2'b11; en = 2'b00; refc = 2'b00; gen = 2'b00;
        err[0] = '0; err[1] = '0; dco[0] = '0; dco[1] = '0;
        m_lost[0] = 0; m_lost[1] = 0;
        model_start(0); model_start(1);
        m_state[0] = 0; m_state[1] = 0;
        #20;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset locked_o", d), locked[d], 0);
            check($sformatf("dut%0d reset lock_lost_o", d), lost[d], 0);
            check($sformatf("dut%0d reset state_o", d), st[d], 0);
            check($sformatf("dut%0d reset gen_count_o", d), gc[d], 0);
            check($sformatf("dut%0d reset window_good_o", d), wg[d], 0);
        end
        rst = 2'b00;
        #20;

        // DIV_RATIO=1, gen_clk = ref_clk: discard window then 16 good windows to lock.
        en[0] = 1'b1;
        model_start(0);
        #30;
        for (int i = 1; i <= 17; i++)
            win(0, (i == 2) ? 8'd4 : (i == 3) ? 8'hFC : 8'd0,
                (i == 4) ? 5'd14 : (i == 5) ? 5'h11 : 5'd0, 1, 0, 0.0, 0.0, 1'b0);
        for (int i = 0; i < 4; i++) win(0, 8'd5, 5'd0, 1, 0, 0.0, 0.0, 1'b0);
        for (int i = 0; i < 16; i++) win(0, 8'd0, 5'd0, 1, 0, 0.0, 0.0, 1'b0);
        for (int i = 0; i < 8; i++) win(0, p4e[i], p4c[i], p4g[i], 0, 0.0, 0.0, 1'b0);
        win(0, 8'd0, 5'd0, 1, 0, 0.0, 0.0, 1'b1);

        #100;
        en[0] = 1'b1;
        model_start(0);
        for (int i = 0; i < 20; i++) win(0, 8'd0, 5'h10, 1, 0, 0.0, 0.0, 1'b0);
        for (int i = 0; i < 16; i++) win(0, 8'd0, 5'd0, 1, 0, 0.0, 0.0, 1'b0);

        check("dut0 locked_o before reset", locked[0], 1);
        rst[0] = 1'b1;
        #1;
        check("dut0 async reset locked_o", locked[0], 0);
        check("dut0 async reset lock_lost_o", lost[0], 0);
        check("dut0 async reset state_o", st[0], 0);
        check("dut0 async reset gen_count_o", gc[0], 0);
        check("dut0 async reset window_good_o", wg[0], 0);
        #19;
        rst[0] = 1'b0;
        model_start(0);
        #30;
        for (int i = 0; i < 2; i++) win(0, 8'd0, 5'd0, 1, 0, 0.0, 0.0, 1'b0);
        check("dut0 lock_lost_o pulse cycles", lost_cnt[0], m_lost[0]);

        // DIV_RATIO=8: 8 gen pulses per 200 ns lock; 9 pulses per window loses lock.
        en[1] = 1'b1;
        model_start(1);
        #30;
        for (int i = 0; i < 17; i++) win(1, 8'd0, 5'd0, 0, 8, 12.5, 12.0, 1'b0);
        for (int i = 0; i < 5; i++) win(1, 8'd0, 5'd0, 0, 9, 11.0, 12.0, 1'b0);
        check("dut1 lock_lost_o pulse cycles", lost_cnt[1], m_lost[1]);

        #50;
        check("dut0 scoreboard drained", q0.size(), 0);
        check("dut1 scoreboard drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
